// File: rtl/hazard_ctrl.sv
// Hazard / pipeline sequencer for the 5-stage MIPS core: load-use stalls, branch/jump
// flushes, multiply/divide wait with timeout, interrupt take. Optional HAZARD_PERF_CNT_EN adds perf counters.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic       ID_jump,
  input  logic       EX_MemRd,
  input  logic [4:0] EX_WrReg,
  input  logic       EX_branch_taken,
  input  logic       EX_is_md,
  input  logic       md_done,
  input  logic       irq_req,
  output logic       pc_hold,
  output logic       ifid_hold,
  output logic       idex_hold,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       md_start,
  output logic       md_timeout,
  output logic       irq_take,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_md_cyc
`endif
);

  typedef enum logic {S_RUN, S_MD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu, lu_fire;

  assign lu = EX_MemRd && (EX_WrReg != 5'd0) &&
              ((ID_uses_rs && (ID_rs == EX_WrReg)) || (ID_uses_rt && (ID_rt == EX_WrReg)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    md_start     = 1'b0;
    md_timeout   = 1'b0;
    irq_take     = 1'b0;
    busy         = 1'b0;
    lu_fire      = 1'b0;
    // Outputs are combinational, so they must be forced low while reset is held.
    if (reset) begin
      busy = (state != S_RUN);
      case (state)
        S_RUN: begin
          cnt_nxt = '0;
          if (EX_is_md) begin
            md_start     = 1'b1;
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = S_MD;
          end else if (EX_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            lu_fire     = 1'b1;
          end else if (ID_jump) begin
            ifid_flush = 1'b1;
          end else if (irq_req) begin
            irq_take    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        S_MD: begin
          cnt_nxt = cnt + 1'b1;
          if (md_done) begin
            // Release in the done cycle so the EX result advances; no md_start here.
            cnt_nxt   = '0;
            state_nxt = S_RUN;
          end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
            md_timeout = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = S_RUN;
          end else begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_bubble = 1'b1;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_lu_cnt    <= '0;
      perf_flush_cnt <= '0;
      perf_md_cyc    <= '0;
    end else begin
      if (lu_fire && (perf_lu_cnt != '1))       perf_lu_cnt    <= perf_lu_cnt + 1'b1;
      if (ifid_flush && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if ((state == S_MD) && (perf_md_cyc != '1)) perf_md_cyc  <= perf_md_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant vector table, directed multi-cycle sequences,
// and random stimulus against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int MD_TIMEOUT = 64;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic urs, urt, jump, memrd;
    logic [4:0] wr;
    logic br, md, done, irq;
  } in_t;

  typedef struct packed {
    logic pc, ifid, idex, flush, idexb, exmemb, start, tmo, take, busy;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] ID_rs, ID_rt, EX_WrReg;
  logic ID_uses_rs, ID_uses_rt, ID_jump, EX_MemRd, EX_branch_taken, EX_is_md, md_done, irq_req;
  logic pc_hold, ifid_hold, idex_hold, ifid_flush, idex_bubble, exmem_bubble;
  logic md_start, md_timeout, irq_take, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_md_cyc;
  longint m_lu, m_fl, m_mdc;
`endif

  hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .ID_jump(ID_jump),
    .EX_MemRd(EX_MemRd), .EX_WrReg(EX_WrReg), .EX_branch_taken(EX_branch_taken),
    .EX_is_md(EX_is_md), .md_done(md_done), .irq_req(irq_req),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .md_start(md_start), .md_timeout(md_timeout), .irq_take(irq_take), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_md_cyc(perf_md_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit m_md = 1'b0;   // model: inside a multiply/divide wait
  int m_cyc = 0;     // model: 1-based index of the current wait cycle

  function automatic out_t dut_o();
    return {pc_hold, ifid_hold, idex_hold, ifid_flush, idex_bubble, exmem_bubble,
            md_start, md_timeout, irq_take, busy};
  endfunction

  function automatic bit is_lu(in_t i);
    return i.memrd && i.wr != 0 && ((i.urs && i.rs == i.wr) || (i.urt && i.rt == i.wr));
  endfunction

  function automatic out_t model_eval(in_t i);
    out_t o = '0;
    if (m_md) begin
      o.busy = 1'b1;
      if (!i.done) begin
        if (m_cyc == MD_TIMEOUT) o.tmo = 1'b1;
        else {o.pc, o.ifid, o.idex, o.exmemb} = 4'hF;
      end
    end else if (i.md)       {o.start, o.pc, o.ifid, o.idex, o.exmemb} = 5'h1F;
    else if (i.br)           {o.flush, o.idexb} = 2'b11;
    else if (is_lu(i))       {o.pc, o.ifid, o.idexb} = 3'b111;
    else if (i.jump)         o.flush = 1'b1;
    else if (i.irq)          {o.take, o.flush, o.idexb} = 3'b111;
    return o;
  endfunction

  task automatic model_step(in_t i);
    out_t o = model_eval(i);
`ifdef HAZARD_PERF_CNT_EN
    if (!m_md && !i.md && !i.br && is_lu(i)) m_lu++;
    if (o.flush) m_fl++;
    if (m_md) m_mdc++;
`endif
    if (!m_md) begin
      if (i.md) begin m_md = 1'b1; m_cyc = 1; end
    end else if (i.done || m_cyc == MD_TIMEOUT) begin
      m_md = 1'b0; m_cyc = 0;
    end else m_cyc++;
    if (o.busy && !m_md && o.start) m_cyc = m_cyc; // unreachable pairing guard, no effect
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(in_t i);
    ID_rs = i.rs; ID_rt = i.rt; ID_uses_rs = i.urs; ID_uses_rt = i.urt; ID_jump = i.jump;
    EX_MemRd = i.memrd; EX_WrReg = i.wr; EX_branch_taken = i.br; EX_is_md = i.md;
    md_done = i.done; irq_req = i.irq;
  endtask

  // One clock: drive at posedge+1, check at negedge against an expected value, advance model.
  task automatic cyc(string name, in_t i, out_t e);
    apply(i);
    @(negedge clk);
    chk(name, 32'(dut_o()), 32'(e));
    model_step(i);
    @(posedge clk); #1;
  endtask

  function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic jump,
                             logic memrd, logic [4:0] wr, logic br, logic md, logic done, logic irq);
    in_t i;
    i = '{rs:rs, rt:rt, urs:urs, urt:urt, jump:jump, memrd:memrd, wr:wr,
          br:br, md:md, done:done, irq:irq};
    return i;
  endfunction

  localparam out_t O_IDLE  = 10'b0000000000;
  localparam out_t O_LU    = 10'b1100100000;
  localparam out_t O_JMP   = 10'b0001000000;
  localparam out_t O_BR    = 10'b0001100000;
  localparam out_t O_IRQ   = 10'b0001100010;
  localparam out_t O_START = 10'b1110011000;
  localparam out_t O_WAIT  = 10'b1110010001;
  localparam out_t O_DONE  = 10'b0000000001;
  localparam out_t O_TMO   = 10'b0000000101;

  vec_t tbl[$];
  in_t  idle, mdi, r;

  initial begin
    idle = '0;
    mdi  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl.push_back('{"idle",        mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0), O_IDLE});
    tbl.push_back('{"lu_rs",       mk(8, 9, 1, 1, 0, 1, 8, 0, 0, 0, 0), O_LU});
    tbl.push_back('{"lu_r0",       mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0), O_IDLE});
    tbl.push_back('{"lu_rt_unused",mk(3, 8, 1, 0, 0, 1, 8, 0, 0, 0, 0), O_IDLE});
    tbl.push_back('{"lu_rt",       mk(3, 8, 1, 1, 0, 1, 8, 0, 0, 0, 0), O_LU});
    tbl.push_back('{"lu_no_load",  mk(8, 8, 1, 1, 0, 0, 8, 0, 0, 0, 0), O_IDLE});
    tbl.push_back('{"jump",        mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), O_JMP});
    tbl.push_back('{"irq",         mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_IRQ});
    tbl.push_back('{"br_lu_irq",   mk(8, 0, 1, 0, 1, 1, 8, 1, 0, 0, 1), O_BR});
    tbl.push_back('{"lu_jump",     mk(8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 1), O_LU});
    tbl.push_back('{"jump_irq",    mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), O_JMP});
    tbl.push_back('{"done_in_run", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_IDLE});

    // Reset state with a load-use pattern on the inputs.
    apply(mk(8, 0, 1, 0, 1, 1, 8, 1, 1, 0, 1));
    #2 chk("reset_outputs", 32'(dut_o()), 32'(O_IDLE));
    @(posedge clk); @(posedge clk); #1;
    apply(idle);
    reset = 1'b1;

    foreach (tbl[k]) cyc(tbl[k].name, tbl[k].i, tbl[k].e);

    // lw $8 then add reading $8: one stall cycle, then the load has moved on.
    cyc("lu_seq_stall", mk(8, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0), O_LU);
    cyc("lu_seq_after", mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), O_IDLE);

    // Branch beats load-use and irq; the pended irq is taken on the next clean cycle.
    cyc("br_pend_irq", mk(8, 0, 1, 0, 0, 1, 8, 1, 0, 0, 1), O_BR);
    cyc("irq_taken",   mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_IRQ);

    // MD with done on the 6th wait cycle: 6 hold cycles, one start, release on done.
    cyc("md_start", mdi, O_START);
    for (int k = 0; k < 5; k++) cyc("md_wait", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), O_WAIT);
    cyc("md_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_DONE);
    cyc("md_after_done", idle, O_IDLE);

    // MD timeout: pulse on wait cycle 64.
    cyc("tmo_start", mdi, O_START);
    for (int k = 1; k < MD_TIMEOUT; k++) cyc("tmo_wait", idle, O_WAIT);
    cyc("tmo_pulse", idle, O_TMO);
    cyc("tmo_after", idle, O_IDLE);

    // Reset during MD wait cycle 3 abandons the operation silently.
    cyc("rst_md_start", mdi, O_START);
    cyc("rst_md_w1", idle, O_WAIT);
    cyc("rst_md_w2", idle, O_WAIT);
    apply(mk(8, 0, 1, 0, 1, 1, 8, 1, 1, 0, 1));
    #2 reset = 1'b0;
    #1 chk("rst_md_outputs", 32'(dut_o()), 32'(O_IDLE));
    m_md = 1'b0; m_cyc = 0;
    @(posedge clk); #1;
    apply(idle);
    reset = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    m_lu = 0; m_fl = 0; m_mdc = 0;
    #1 chk("perf_zero", perf_lu_cnt | perf_flush_cnt | perf_md_cyc, 32'd0);
    @(posedge clk); #1;
`endif
    cyc("rst_after", idle, O_IDLE);
    // Counter restarted at 0: a fresh wait still times out on cycle 64.
    cyc("rst_md2_start", mdi, O_START);
    for (int k = 1; k < MD_TIMEOUT; k++) cyc("rst_md2_wait", idle, O_WAIT);
    cyc("rst_md2_tmo", idle, O_TMO);

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      r.rs    = 5'($urandom_range(0, 3));
      r.rt    = 5'($urandom_range(0, 3));
      r.wr    = 5'($urandom_range(0, 3));
      r.urs   = 1'($urandom_range(0, 1));
      r.urt   = 1'($urandom_range(0, 1));
      r.memrd = 1'($urandom_range(0, 1));
      r.jump  = ($urandom_range(0, 5) == 0);
      r.br    = ($urandom_range(0, 5) == 0);
      r.md    = ($urandom_range(0, 15) == 0);
      r.done  = ($urandom_range(0, 5) == 0);
      r.irq   = ($urandom_range(0, 3) == 0);
      cyc("random", r, model_eval(r));
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu_cnt",    perf_lu_cnt,    32'(m_lu));
    chk("perf_flush_cnt", perf_flush_cnt, 32'(m_fl));
    chk("perf_md_cyc",    perf_md_cyc,    32'(m_mdc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core. Generates hold, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Sources: load-use hazards, taken branches/jumps, and the multi-cycle multiply/divide unit (start/done handshake).
- Accepts external interrupts at safe points.
- Sits beside the ID stage. Its idex_bubble output drives the ID/EX register's stall input, which zeroes MemWr/MemRd/RegWr.

Parameters:
- MD_TIMEOUT, 64: maximum S_MD cycles before the operation is abandoned.
- CNT_W, 7: width of the MD wait counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ID_rs, ID_rt  in  5  ID-stage source registers.
- ID_uses_rs, ID_uses_rt  in  1  ID instruction reads rs / rt.
- ID_jump  in  1  ID holds j/jal/jr/jalr (resolved in ID).
- EX_MemRd  in  1  EX instruction is a load.
- EX_WrReg  in  5  EX destination register.
- EX_branch_taken  in  1  EX branch resolved taken.
- EX_is_md  in  1  EX instruction is mult/div.
- md_done  in  1  MD unit result valid (one-cycle pulse).
- irq_req  in  1  level interrupt request.
- pc_hold, ifid_hold, idex_hold  out  1  freeze the register.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  zero ID/EX control.
- exmem_bubble  out  1  zero EX/MEM control.
- md_start  out  1  start pulse to MD unit.
- md_timeout  out  1  one-cycle error pulse.
- irq_take  out  1  one-cycle pulse: redirect PC to handler, capture EPC.
- busy  out  1  state != S_RUN.

Behaviour:
- Outputs are combinational from state and inputs (same-cycle effect). While reset = 0, every output is 0, state is S_RUN and the counter is 0. Reset asserted mid-S_MD abandons the operation with no md_timeout pulse.
- Load-use hit (lu): EX_MemRd and EX_WrReg != 0 and ((ID_uses_rs and ID_rs == EX_WrReg) or (ID_uses_rt and ID_rt == EX_WrReg)).
- S_RUN evaluates the following in fixed priority order; exactly one action fires per cycle.
  1. EX_is_md: md_start = 1 and go to S_MD. Same cycle: pc_hold = ifid_hold = idex_hold = 1 and exmem_bubble = 1.
  2. EX_branch_taken: ifid_flush = 1 and idex_bubble = 1. lu and ID_jump are ignored because the ID instruction is squashed.
  3. lu: pc_hold = ifid_hold = 1 and idex_bubble = 1, for one cycle only. The load moves to MEM, so lu clears on the next cycle.
  4. ID_jump: ifid_flush = 1.
  5. irq_req: irq_take = 1, ifid_flush = 1, idex_bubble = 1. An interrupt is never taken in the same cycle as 1–4, and is pended until a clean cycle.
- S_MD: md_start = 0, and the counter increments every cycle.
  - md_done = 1: all holds and bubbles released in that same cycle (the EX result advances), counter cleared, go to S_RUN.
  - Counter == MD_TIMEOUT-1 without md_done: md_timeout = 1, holds released as for done, go to S_RUN.
  - Otherwise: pc_hold = ifid_hold = idex_hold = 1 and exmem_bubble = 1.
- Re-trigger guard: the S_MD→S_RUN transition cycle never asserts md_start, even though EX_is_md is still high for the completing instruction.
- irq_req and EX_branch_taken are ignored in S_MD.
- md_done in S_RUN is ignored.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lu_cnt[31:0], perf_flush_cnt[31:0] and perf_md_cyc[31:0], each reset to 0.
  - perf_lu_cnt increments on each cycle that case 3 fires.
  - perf_flush_cnt increments on each cycle with ifid_flush = 1.
  - perf_md_cyc increments on each cycle in S_MD.
  - All three saturate at 32'hFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- lw $8 in EX (EX_MemRd = 1, EX_WrReg = 8), ID add reading rs = 8 -> exactly one cycle of pc_hold = ifid_hold = idex_bubble = 1, then all 0.
- Load-use with EX_WrReg = 0 -> no stall. Load-use with ID_uses_rt = 0 and only an rt match -> no stall.
- EX_branch_taken with lu and irq_req also high -> ifid_flush = idex_bubble = 1, pc_hold = 0, irq_take = 0. Next clean cycle -> irq_take = 1.
- EX_is_md, md_done after 5 cycles -> md_start pulses once, holds high for 6 cycles total, released on the done cycle, no second md_start.
- EX_is_md, md_done never arrives, MD_TIMEOUT = 64 -> md_timeout pulses on S_MD cycle 64, then busy = 0.
- reset = 0 during S_MD cycle 3 -> all outputs 0 immediately. After release: S_RUN, counter 0, and (with HAZARD_PERF_CNT_EN) perf counters 0.
